ctrl_pipeline: RTL and testbench
================================

Name: ctrl_pipeline

Overview:
- Consumer end of the ID-stage control decoder in the 5-stage RV32I pipeline.
- Carries the decoded control word through the ID/EX, EX/MEM and MEM/WB registers.
- Detects load-use hazards, generates forwarding selects and flushes on EX-resolved redirects.
- Sits between the decoder and the datapath; the datapath mux selects come only from this block.

Parameters:
- REG_ADDR_W, 5, register-index width.
- ALU_OP_W, 3, width of the ALU operation select.

Ports:
- clk  in  1  core clock.
- rst_n  in  1  asynchronous active-low reset.
- id_valid  in  1  ID holds a real instruction.
- id_write, id_store, id_load, id_branch  in  1 each  decoder control bits.
- id_alu_a_sel  in  2  ALU operand A select.
- id_alu_b_sel  in  1  ALU operand B select.
- id_next_pc_sel  in  2  next-PC select: 00 seq, 01 jalr, 10 branch, 11 jal.
- id_alu_op  in  ALU_OP_W  ALU operation.
- id_rd, id_rs1, id_rs2  in  REG_ADDR_W each  register indices.
- id_uses_rs1, id_uses_rs2  in  1 each  the instruction reads that source.
- ex_branch_taken  in  1  branch comparator result in EX.
- ex_valid, ex_write, ex_load, ex_branch  out  1 each  EX-stage control.
- ex_alu_a_sel  out  2  EX-stage ALU operand A select.
- ex_alu_b_sel  out  1  EX-stage ALU operand B select.
- ex_alu_op  out  ALU_OP_W  EX-stage ALU operation.
- ex_next_pc_sel  out  2  EX-stage next-PC select.
- fwd_a_sel, fwd_b_sel  out  2 each  forwarding selects: 00 regfile, 01 MEM result, 10 WB result.
- mem_valid, mem_store, mem_load  out  1 each  MEM-stage control.
- wb_write  out  1  register-file write enable.
- wb_rd  out  REG_ADDR_W  register-file write index.
- wb_sel_load  out  1  write-back source is load data.
- stall  out  1  hold PC and IF/ID.
- flush  out  1  squash IF/ID.
- redirect  out  1  PC takes the EX target.

Behaviour:
- Reset: every stage register and every registered output is 0; pipeline holds bubbles only.
- Combinational outputs (stall, flush, redirect, fwd_*) are 0 while ID and EX are invalid.
- Stage advance: each rising edge moves ID to EX, EX to MEM, MEM to WB. No back-pressure from MEM or WB.
- Bubble: a bubble clears every control bit of the stage, not only the valid bit. Invalid stages never write, store, load or redirect.
- redirect: asserted when ex_valid and either ex_next_pc_sel is 01 or 11, or ex_branch is 1 and ex_branch_taken is 1.
- On redirect:
  - flush is asserted.
  - EX loads a bubble at the next edge.
  - stall is forced to 0 in the same cycle; redirect has priority over a load-use stall.
- Load-use stall: asserted when all of the following hold:
  - ex_valid and ex_load;
  - ex_rd is not 0;
  - ex_rd matches id_rs1 with id_uses_rs1, or id_rs2 with id_uses_rs2;
  - id_valid is 1.
- During a stall, EX loads a bubble at the next edge. ID is held by upstream; the same ID word is re-evaluated in the next cycle.
- Stall lasts exactly 1 cycle per load-use hazard; the load then sits in MEM and its data is forwarded from WB.
- Forwarding, evaluated per operand on the EX-stage rs1/rs2 (registered copies of the id_rs*):
  - 01 if mem_valid, MEM write is set, MEM is not a load, MEM rd is not 0 and MEM rd matches.
  - Otherwise 10 if wb_write is set, wb_rd is not 0 and wb_rd matches.
  - Otherwise 00.
  - MEM has priority over WB.
- x0: rd = 0 never forwards and never stalls. wb_write stays as decoded; the regfile ignores x0.
- Latency: control for an instruction appears on ex_* 1 cycle after it is accepted in ID, mem_* after 2 cycles, wb_* after 3 cycles.
- Reset asserted mid-operation: all stages clear immediately and asynchronously. After release the first valid ID word reaches EX 1 edge later.

Decomposition:
- Package rv32i_ctrl_pkg holds:
  - ctrl_t struct (write, store, load, branch, alu_a_sel, alu_b_sel, next_pc_sel, alu_op, rd, valid);
  - next_pc_sel and fwd_sel enums;
  - the CTRL_BUBBLE constant.
- One combinational sub-module, hazard_forward_unit: load-use detection plus both forwarding selects.
- Stage registers and redirect logic stay in ctrl_pipeline.

Test Plan:
- Reset release, 3 ALU ops (addi x1, x2, x3) -> ex/mem/wb valid ripple at cycles 1/2/3; wb_rd goes 1,2,3 with wb_write=1; stall=flush=0 throughout.
- lw x5 followed by add x6,x5,x7 -> stall=1 for exactly 1 cycle; EX holds a bubble (all control 0); the add then sees fwd_a_sel=10.
- add x4 then sub x8,x4,x4 back-to-back -> fwd_a_sel=fwd_b_sel=01. With one independent instruction between them -> both 10.
- Taken branch in EX (ex_branch=1, ex_branch_taken=1) while ID holds a load-use consumer -> redirect=flush=1, stall=0; next EX is a bubble.
- jal (next_pc_sel=11) writing x0, followed by a reader of x0 -> redirect=1; no forwarding, fwd_*=00.
- rst_n pulsed low for 1 cycle with 3 instructions in flight -> all outputs 0 at once; no wb_write afterwards for the squashed instructions.

Source files
------------

// File: rtl/rv32i_ctrl_pkg.sv
// Shared types for the RV32I control pipeline: decoded control word, per-stage
// payloads, select encodings and the bubble constant.
package rv32i_ctrl_pkg;

    localparam int unsigned REG_ADDR_W = 5;
    localparam int unsigned ALU_OP_W   = 3;

    typedef enum logic [1:0] {
        NPC_SEQ    = 2'b00,
        NPC_JALR   = 2'b01,
        NPC_BRANCH = 2'b10,
        NPC_JAL    = 2'b11
    } next_pc_sel_t;

    typedef enum logic [1:0] {
        FWD_RF  = 2'b00,
        FWD_MEM = 2'b01,
        FWD_WB  = 2'b10
    } fwd_sel_t;

    typedef struct packed {
        logic                  write;
        logic                  store;
        logic                  load;
        logic                  branch;
        logic [1:0]            alu_a_sel;
        logic                  alu_b_sel;
        next_pc_sel_t          next_pc_sel;
        logic [ALU_OP_W-1:0]   alu_op;
        logic [REG_ADDR_W-1:0] rd;
        logic                  valid;
    } ctrl_t;

    // MEM and WB only keep the fields their consumers still need
    typedef struct packed {
        logic                  valid;
        logic                  write;
        logic                  store;
        logic                  load;
        logic [REG_ADDR_W-1:0] rd;
    } mem_t;

    typedef struct packed {
        logic                  write;
        logic                  load;
        logic [REG_ADDR_W-1:0] rd;
    } wb_t;

    localparam ctrl_t CTRL_BUBBLE = '{
        write:       1'b0,
        store:       1'b0,
        load:        1'b0,
        branch:      1'b0,
        alu_a_sel:   2'b00,
        alu_b_sel:   1'b0,
        next_pc_sel: NPC_SEQ,
        alu_op:      ALU_OP_W'(0),
        rd:          REG_ADDR_W'(0),
        valid:       1'b0
    };

    function automatic mem_t to_mem(ctrl_t c);
        return '{valid: c.valid, write: c.write, store: c.store, load: c.load, rd: c.rd};
    endfunction

    function automatic wb_t to_wb(mem_t m);
        return '{write: m.write, load: m.load, rd: m.rd};
    endfunction

    // Jumps always leave the sequential path; branches only when the comparator agrees
    function automatic logic is_redirect(ctrl_t c, logic taken);
        return c.valid && ((c.next_pc_sel == NPC_JALR) || (c.next_pc_sel == NPC_JAL) ||
                           (c.branch && taken));
    endfunction

endpackage

// File: rtl/ctrl_pipeline_hazard_forward_unit.sv
// Load-use hazard detection and per-operand forwarding selects for the EX stage.
module hazard_forward_unit
    import rv32i_ctrl_pkg::*;
(
    input  logic                  id_valid,
    input  logic [REG_ADDR_W-1:0] id_rs1,
    input  logic [REG_ADDR_W-1:0] id_rs2,
    input  logic                  id_uses_rs1,
    input  logic                  id_uses_rs2,
    input  logic                  ex_valid,
    input  logic                  ex_load,
    input  logic [REG_ADDR_W-1:0] ex_rd,
    input  logic [REG_ADDR_W-1:0] ex_rs1,
    input  logic [REG_ADDR_W-1:0] ex_rs2,
    input  logic                  mem_valid,
    input  logic                  mem_write,
    input  logic                  mem_load,
    input  logic [REG_ADDR_W-1:0] mem_rd,
    input  logic                  wb_write,
    input  logic [REG_ADDR_W-1:0] wb_rd,
    output logic                  load_use_c,
    output fwd_sel_t              fwd_a_sel_c,
    output fwd_sel_t              fwd_b_sel_c
);

    logic mem_fwd_ok;
    logic wb_fwd_ok;

    // A load in MEM has no data yet; it is covered by the stall plus WB forwarding
    assign mem_fwd_ok = mem_valid && mem_write && !mem_load && (mem_rd != REG_ADDR_W'(0));
    assign wb_fwd_ok  = wb_write && (wb_rd != REG_ADDR_W'(0));

    function automatic fwd_sel_t pick(logic [REG_ADDR_W-1:0] rs, logic m_ok,
                                      logic [REG_ADDR_W-1:0] m_rd, logic w_ok,
                                      logic [REG_ADDR_W-1:0] w_rd);
        if (m_ok && (m_rd == rs)) return FWD_MEM;
        if (w_ok && (w_rd == rs)) return FWD_WB;
        return FWD_RF;
    endfunction

    always_comb begin
        load_use_c  = 1'b0;
        fwd_a_sel_c = FWD_RF;
        fwd_b_sel_c = FWD_RF;
        if (ex_valid) begin
            fwd_a_sel_c = pick(ex_rs1, mem_fwd_ok, mem_rd, wb_fwd_ok, wb_rd);
            fwd_b_sel_c = pick(ex_rs2, mem_fwd_ok, mem_rd, wb_fwd_ok, wb_rd);
        end
        if (id_valid && ex_valid && ex_load && (ex_rd != REG_ADDR_W'(0)) &&
            ((id_uses_rs1 && (id_rs1 == ex_rd)) || (id_uses_rs2 && (id_rs2 == ex_rd)))) begin
            load_use_c = 1'b1;
        end
    end

endmodule

// File: rtl/ctrl_pipeline.sv
// ID/EX, EX/MEM and MEM/WB control registers with redirect, stall and
// forwarding select generation for the 5-stage RV32I datapath.
module ctrl_pipeline
    import rv32i_ctrl_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  id_valid,
    input  logic                  id_write,
    input  logic                  id_store,
    input  logic                  id_load,
    input  logic                  id_branch,
    input  logic [1:0]            id_alu_a_sel,
    input  logic                  id_alu_b_sel,
    input  logic [1:0]            id_next_pc_sel,
    input  logic [ALU_OP_W-1:0]   id_alu_op,
    input  logic [REG_ADDR_W-1:0] id_rd,
    input  logic [REG_ADDR_W-1:0] id_rs1,
    input  logic [REG_ADDR_W-1:0] id_rs2,
    input  logic                  id_uses_rs1,
    input  logic                  id_uses_rs2,
    input  logic                  ex_branch_taken,
    output logic                  ex_valid,
    output logic                  ex_write,
    output logic                  ex_load,
    output logic                  ex_branch,
    output logic [1:0]            ex_alu_a_sel,
    output logic                  ex_alu_b_sel,
    output logic [ALU_OP_W-1:0]   ex_alu_op,
    output logic [1:0]            ex_next_pc_sel,
    output logic [1:0]            fwd_a_sel,
    output logic [1:0]            fwd_b_sel,
    output logic                  mem_valid,
    output logic                  mem_store,
    output logic                  mem_load,
    output logic                  wb_write,
    output logic [REG_ADDR_W-1:0] wb_rd,
    output logic                  wb_sel_load,
    output logic                  stall,
    output logic                  flush,
    output logic                  redirect
);

    ctrl_t                 id_word;
    ctrl_t                 ex_q;
    mem_t                  mem_q;
    wb_t                   wb_q;
    logic [REG_ADDR_W-1:0] ex_rs1_q;
    logic [REG_ADDR_W-1:0] ex_rs2_q;
    logic                  redirect_c;
    logic                  load_use_c;
    logic                  stall_c;
    logic                  ex_take_c;
    fwd_sel_t              fwd_a_c;
    fwd_sel_t              fwd_b_c;

    always_comb begin
        id_word             = CTRL_BUBBLE;
        id_word.valid       = id_valid;
        id_word.write       = id_write;
        id_word.store       = id_store;
        id_word.load        = id_load;
        id_word.branch      = id_branch;
        id_word.alu_a_sel   = id_alu_a_sel;
        id_word.alu_b_sel   = id_alu_b_sel;
        id_word.next_pc_sel = next_pc_sel_t'(id_next_pc_sel);
        id_word.alu_op      = id_alu_op;
        id_word.rd          = id_rd;
    end

    hazard_forward_unit u_hazard (
        .id_valid    (id_valid),
        .id_rs1      (id_rs1),
        .id_rs2      (id_rs2),
        .id_uses_rs1 (id_uses_rs1),
        .id_uses_rs2 (id_uses_rs2),
        .ex_valid    (ex_q.valid),
        .ex_load     (ex_q.load),
        .ex_rd       (ex_q.rd),
        .ex_rs1      (ex_rs1_q),
        .ex_rs2      (ex_rs2_q),
        .mem_valid   (mem_q.valid),
        .mem_write   (mem_q.write),
        .mem_load    (mem_q.load),
        .mem_rd      (mem_q.rd),
        .wb_write    (wb_q.write),
        .wb_rd       (wb_q.rd),
        .load_use_c  (load_use_c),
        .fwd_a_sel_c (fwd_a_c),
        .fwd_b_sel_c (fwd_b_c)
    );

    // A redirect squashes the ID word anyway, so it overrides any load-use stall
    assign redirect_c = is_redirect(ex_q, ex_branch_taken);
    assign stall_c    = load_use_c && !redirect_c;
    assign ex_take_c  = id_valid && !stall_c && !redirect_c;

    // Bubbles zero the whole word so squashed slots cannot write, store, load or redirect
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ex_q     <= CTRL_BUBBLE;
            mem_q    <= to_mem(CTRL_BUBBLE);
            wb_q     <= to_wb(to_mem(CTRL_BUBBLE));
            ex_rs1_q <= REG_ADDR_W'(0);
            ex_rs2_q <= REG_ADDR_W'(0);
        end else begin
            ex_q     <= ex_take_c ? id_word : CTRL_BUBBLE;
            ex_rs1_q <= (ex_take_c && id_uses_rs1) ? id_rs1 : REG_ADDR_W'(0);
            ex_rs2_q <= (ex_take_c && id_uses_rs2) ? id_rs2 : REG_ADDR_W'(0);
            mem_q    <= to_mem(ex_q);
            wb_q     <= to_wb(mem_q);
        end
    end

    assign ex_valid       = ex_q.valid;
    assign ex_write       = ex_q.write;
    assign ex_load        = ex_q.load;
    assign ex_branch      = ex_q.branch;
    assign ex_alu_a_sel   = ex_q.alu_a_sel;
    assign ex_alu_b_sel   = ex_q.alu_b_sel;
    assign ex_alu_op      = ex_q.alu_op;
    assign ex_next_pc_sel = ex_q.next_pc_sel;
    assign mem_valid      = mem_q.valid;
    assign mem_store      = mem_q.store;
    assign mem_load       = mem_q.load;
    assign wb_write       = wb_q.write;
    assign wb_rd          = wb_q.rd;
    assign wb_sel_load    = wb_q.load;
    assign fwd_a_sel      = fwd_a_c;
    assign fwd_b_sel      = fwd_b_c;
    assign stall          = stall_c;
    assign flush          = redirect_c;
    assign redirect       = redirect_c;

endmodule

// File: tb/tb_ctrl_pipeline.sv
// Scenario bench for ctrl_pipeline; retirements are checked against a queue of
// expected register-file writes filled as instructions are issued.
module tb_ctrl_pipeline;

    logic       clk;
    logic       rst_n;
    logic       id_valid, id_write, id_store, id_load, id_branch;
    logic [1:0] id_alu_a_sel;
    logic       id_alu_b_sel;
    logic [1:0] id_next_pc_sel;
    logic [2:0] id_alu_op;
    logic [4:0] id_rd, id_rs1, id_rs2;
    logic       id_uses_rs1, id_uses_rs2;
    logic       ex_branch_taken;
    logic       ex_valid, ex_write, ex_load, ex_branch;
    logic [1:0] ex_alu_a_sel;
    logic       ex_alu_b_sel;
    logic [2:0] ex_alu_op;
    logic [1:0] ex_next_pc_sel;
    logic [1:0] fwd_a_sel, fwd_b_sel;
    logic       mem_valid, mem_store, mem_load;
    logic       wb_write;
    logic [4:0] wb_rd;
    logic       wb_sel_load;
    logic       stall, flush, redirect;

    typedef struct {
        logic [4:0] rd;
        logic       ld;
    } wb_exp_t;

    wb_exp_t sb_q[$];
    wb_exp_t mon_e;
    int      n_checks = 0;
    int      n_fail   = 0;

    logic [28:0] all_outs;
    logic [11:0] ex_ctrl;
    assign all_outs = {ex_valid, ex_write, ex_load, ex_branch, ex_alu_a_sel, ex_alu_b_sel,
                       ex_alu_op, ex_next_pc_sel, fwd_a_sel, fwd_b_sel, mem_valid, mem_store,
                       mem_load, wb_write, wb_rd, wb_sel_load, stall, flush, redirect};
    assign ex_ctrl  = {ex_valid, ex_write, ex_load, ex_branch, ex_alu_a_sel, ex_alu_b_sel,
                       ex_alu_op, ex_next_pc_sel};

    ctrl_pipeline dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .id_valid        (id_valid),
        .id_write        (id_write),
        .id_store        (id_store),
        .id_load         (id_load),
        .id_branch       (id_branch),
        .id_alu_a_sel    (id_alu_a_sel),
        .id_alu_b_sel    (id_alu_b_sel),
        .id_next_pc_sel  (id_next_pc_sel),
        .id_alu_op       (id_alu_op),
        .id_rd           (id_rd),
        .id_rs1          (id_rs1),
        .id_rs2          (id_rs2),
        .id_uses_rs1     (id_uses_rs1),
        .id_uses_rs2     (id_uses_rs2),
        .ex_branch_taken (ex_branch_taken),
        .ex_valid        (ex_valid),
        .ex_write        (ex_write),
        .ex_load         (ex_load),
        .ex_branch       (ex_branch),
        .ex_alu_a_sel    (ex_alu_a_sel),
        .ex_alu_b_sel    (ex_alu_b_sel),
        .ex_alu_op       (ex_alu_op),
        .ex_next_pc_sel  (ex_next_pc_sel),
        .fwd_a_sel       (fwd_a_sel),
        .fwd_b_sel       (fwd_b_sel),
        .mem_valid       (mem_valid),
        .mem_store       (mem_store),
        .mem_load        (mem_load),
        .wb_write        (wb_write),
        .wb_rd           (wb_rd),
        .wb_sel_load     (wb_sel_load),
        .stall           (stall),
        .flush           (flush),
        .redirect        (redirect)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Every register-file write must match the oldest outstanding expected retirement
    always @(negedge clk) begin
        if (rst_n && wb_write) begin
            n_checks++;
            if (sb_q.size() == 0) begin
                n_fail++;
                $display("FAIL sb_unexpected_write: got wb_rd=%0d, expected no write", wb_rd);
            end else begin
                mon_e = sb_q.pop_front();
                if (wb_rd !== mon_e.rd || wb_sel_load !== mon_e.ld) begin
                    n_fail++;
                    $display("FAIL sb_retire: got rd=%0d ld=%0b, expected rd=%0d ld=%0b",
                             wb_rd, wb_sel_load, mon_e.rd, mon_e.ld);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_id(input logic v, input logic w, input logic st, input logic ld,
                          input logic br, input logic [1:0] nps, input logic [4:0] rd,
                          input logic [4:0] rs1, input logic [4:0] rs2,
                          input logic u1, input logic u2);
        id_valid       = v;
        id_write       = w;
        id_store       = st;
        id_load        = ld;
        id_branch      = br;
        id_next_pc_sel = nps;
        id_rd          = rd;
        id_rs1         = rs1;
        id_rs2         = rs2;
        id_uses_rs1    = u1;
        id_uses_rs2    = u2;
        id_alu_op      = rd[2:0];
        id_alu_a_sel   = rd[1:0];
        id_alu_b_sel   = rd[0];
    endtask

    task automatic set_idle();
        set_id(0, 0, 0, 0, 0, 2'b00, 5'd0, 5'd0, 5'd0, 0, 0);
        ex_branch_taken = 1'b0;
    endtask

    task automatic push(input logic [4:0] rd, input logic ld);
        wb_exp_t e;
        e.rd = rd;
        e.ld = ld;
        sb_q.push_back(e);
    endtask

    task automatic drain(input string name);
        set_idle();
        repeat (4) tick();
        n_checks++;
        if (sb_q.size() != 0) begin
            n_fail++;
            $display("FAIL %s_drain: %0d retirements missing, expected 0", name, sb_q.size());
            sb_q.delete();
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        set_id(1, 1, 1, 1, 1, 2'b11, 5'd9, 5'd9, 5'd9, 1, 1);
        ex_branch_taken = 1'b1;
        repeat (2) tick();
        @(negedge clk);
        n_checks++;
        if (all_outs !== 29'd0) begin
            n_fail++;
            $display("FAIL reset_outputs: got %h, expected 0", all_outs);
        end
        set_idle();
        rst_n = 1'b1;
        @(negedge clk);
        n_checks++;
        if (all_outs !== 29'd0) begin
            n_fail++;
            $display("FAIL idle_after_reset: got %h, expected 0", all_outs);
        end
        tick();
    endtask

    task automatic test_alu_ripple();
        logic       e_ex, e_mem, e_wb;
        logic [4:0] e_rd;
        for (int i = 0; i < 5; i++) begin
            if (i < 3) begin
                set_id(1, 1, 0, 0, 0, 2'b00, 5'(i + 1), 5'd0, 5'd0, 1, 0);
                push(5'(i + 1), 1'b0);
            end else begin
                set_idle();
            end
            @(negedge clk);
            n_checks++;
            if (stall !== 1'b0 || flush !== 1'b0) begin
                n_fail++;
                $display("FAIL ripple_no_stall[%0d]: got stall=%0b flush=%0b, expected 0 0",
                         i, stall, flush);
            end
            tick();
            e_ex  = (i < 3);
            e_mem = (i >= 1 && i < 4);
            e_wb  = (i >= 2);
            e_rd  = (i >= 2) ? 5'(i - 1) : 5'd0;
            n_checks++;
            if ({ex_valid, mem_valid, wb_write, wb_rd} !== {e_ex, e_mem, e_wb, e_rd}) begin
                n_fail++;
                $display("FAIL ripple[%0d]: got ex=%0b mem=%0b wb=%0b rd=%0d, expected %0b %0b %0b %0d",
                         i, ex_valid, mem_valid, wb_write, wb_rd, e_ex, e_mem, e_wb, e_rd);
            end
            if (i < 3) begin
                n_checks++;
                if (ex_alu_op !== 3'(i + 1) || ex_write !== 1'b1) begin
                    n_fail++;
                    $display("FAIL ripple_ex_ctrl[%0d]: got op=%0d write=%0b, expected op=%0d write=1",
                             i, ex_alu_op, ex_write, i + 1);
                end
            end
        end
        drain("ripple");
    endtask

    task automatic test_load_use();
        set_id(1, 1, 0, 1, 0, 2'b00, 5'd5, 5'd1, 5'd0, 1, 0);
        push(5'd5, 1'b1);
        tick();
        set_id(1, 1, 0, 0, 0, 2'b00, 5'd6, 5'd5, 5'd7, 1, 1);
        @(negedge clk);
        n_checks++;
        if ({stall, flush, redirect} !== 3'b100) begin
            n_fail++;
            $display("FAIL load_use_stall: got stall/flush/redirect=%b, expected 100",
                     {stall, flush, redirect});
        end
        tick();
        n_checks++;
        if (ex_ctrl !== 12'd0 || mem_valid !== 1'b1 || mem_load !== 1'b1) begin
            n_fail++;
            $display("FAIL load_use_bubble: got ex_ctrl=%h mem_v=%0b mem_ld=%0b, expected 0 1 1",
                     ex_ctrl, mem_valid, mem_load);
        end
        @(negedge clk);
        n_checks++;
        if (stall !== 1'b0) begin
            n_fail++;
            $display("FAIL load_use_one_cycle: got stall=%0b, expected 0", stall);
        end
        push(5'd6, 1'b0);
        tick();
        n_checks++;
        if (ex_valid !== 1'b1 || fwd_a_sel !== 2'b10 || fwd_b_sel !== 2'b00 ||
            wb_rd !== 5'd5 || wb_sel_load !== 1'b1) begin
            n_fail++;
            $display("FAIL load_use_fwd: got ex_v=%0b fa=%b fb=%b wb_rd=%0d ld=%0b, expected 1 10 00 5 1",
                     ex_valid, fwd_a_sel, fwd_b_sel, wb_rd, wb_sel_load);
        end
        drain("load_use");
    endtask

    task automatic test_forwarding();
        int         gap [3] = '{0, 1, 1};
        logic [4:0] mid [3] = '{5'd0, 5'd9, 5'd4};
        logic [1:0] exp [3] = '{2'b01, 2'b10, 2'b01};
        for (int c = 0; c < 3; c++) begin
            set_id(1, 1, 0, 0, 0, 2'b00, 5'd4, 5'd1, 5'd2, 1, 1);
            push(5'd4, 1'b0);
            tick();
            if (gap[c] != 0) begin
                set_id(1, 1, 0, 0, 0, 2'b00, mid[c], 5'd1, 5'd0, 1, 0);
                push(mid[c], 1'b0);
                tick();
            end
            set_id(1, 1, 0, 0, 0, 2'b00, 5'd8, 5'd4, 5'd4, 1, 1);
            @(negedge clk);
            n_checks++;
            if (stall !== 1'b0) begin
                n_fail++;
                $display("FAIL fwd_no_stall[%0d]: got stall=%0b, expected 0", c, stall);
            end
            push(5'd8, 1'b0);
            tick();
            n_checks++;
            if (fwd_a_sel !== exp[c] || fwd_b_sel !== exp[c]) begin
                n_fail++;
                $display("FAIL fwd_sel[%0d]: got a=%b b=%b, expected %b %b",
                         c, fwd_a_sel, fwd_b_sel, exp[c], exp[c]);
            end
            drain("fwd");
        end
    endtask

    task automatic test_redirect();
        // Not-taken branch: no redirect, the following instruction proceeds
        set_id(1, 0, 0, 0, 1, 2'b10, 5'd0, 5'd1, 5'd2, 1, 1);
        tick();
        set_id(1, 1, 0, 0, 0, 2'b00, 5'd10, 5'd1, 5'd2, 1, 1);
        ex_branch_taken = 1'b0;
        @(negedge clk);
        n_checks++;
        if ({redirect, flush, stall} !== 3'b000) begin
            n_fail++;
            $display("FAIL branch_not_taken: got redirect/flush/stall=%b, expected 000",
                     {redirect, flush, stall});
        end
        push(5'd10, 1'b0);
        tick();
        // Taken branch squashes the ID consumer
        set_id(1, 0, 0, 0, 1, 2'b10, 5'd0, 5'd1, 5'd2, 1, 1);
        tick();
        set_id(1, 1, 0, 0, 0, 2'b00, 5'd6, 5'd5, 5'd5, 1, 1);
        ex_branch_taken = 1'b1;
        @(negedge clk);
        n_checks++;
        if ({redirect, flush, stall} !== 3'b110) begin
            n_fail++;
            $display("FAIL branch_taken: got redirect/flush/stall=%b, expected 110",
                     {redirect, flush, stall});
        end
        tick();
        ex_branch_taken = 1'b0;
        n_checks++;
        if (ex_ctrl !== 12'd0) begin
            n_fail++;
            $display("FAIL branch_bubble: got ex_ctrl=%h, expected 0", ex_ctrl);
        end
        // Jalr-style word that is also a load: redirect must beat the load-use stall
        set_id(1, 1, 0, 1, 0, 2'b01, 5'd5, 5'd1, 5'd0, 1, 0);
        push(5'd5, 1'b1);
        tick();
        set_id(1, 1, 0, 0, 0, 2'b00, 5'd6, 5'd5, 5'd0, 1, 0);
        @(negedge clk);
        n_checks++;
        if ({redirect, flush, stall} !== 3'b110) begin
            n_fail++;
            $display("FAIL redirect_priority: got redirect/flush/stall=%b, expected 110",
                     {redirect, flush, stall});
        end
        tick();
        n_checks++;
        if (ex_ctrl !== 12'd0 || mem_load !== 1'b1) begin
            n_fail++;
            $display("FAIL redirect_priority_bubble: got ex_ctrl=%h mem_ld=%0b, expected 0 1",
                     ex_ctrl, mem_load);
        end
        drain("redirect");
    endtask

    task automatic test_x0();
        set_id(1, 1, 0, 0, 0, 2'b11, 5'd0, 5'd0, 5'd0, 0, 0);
        push(5'd0, 1'b0);
        tick();
        set_id(1, 1, 0, 0, 0, 2'b00, 5'd11, 5'd0, 5'd0, 1, 1);
        @(negedge clk);
        n_checks++;
        if ({redirect, flush, stall} !== 3'b110) begin
            n_fail++;
            $display("FAIL jal_redirect: got redirect/flush/stall=%b, expected 110",
                     {redirect, flush, stall});
        end
        tick();
        push(5'd11, 1'b0);
        tick();
        n_checks++;
        if (ex_valid !== 1'b1 || fwd_a_sel !== 2'b00 || fwd_b_sel !== 2'b00 ||
            wb_write !== 1'b1 || wb_rd !== 5'd0) begin
            n_fail++;
            $display("FAIL x0_wb_no_fwd: got ex_v=%0b fa=%b fb=%b wb_w=%0b wb_rd=%0d, expected 1 00 00 1 0",
                     ex_valid, fwd_a_sel, fwd_b_sel, wb_write, wb_rd);
        end
        drain("x0_jal");
        // Load to x0 never stalls
        set_id(1, 1, 0, 1, 0, 2'b00, 5'd0, 5'd1, 5'd0, 1, 0);
        push(5'd0, 1'b1);
        tick();
        set_id(1, 1, 0, 0, 0, 2'b00, 5'd12, 5'd0, 5'd0, 1, 1);
        @(negedge clk);
        n_checks++;
        if (stall !== 1'b0) begin
            n_fail++;
            $display("FAIL x0_no_stall: got stall=%0b, expected 0", stall);
        end
        push(5'd12, 1'b0);
        tick();
        drain("x0_load");
        // ALU write to x0 in MEM never forwards
        set_id(1, 1, 0, 0, 0, 2'b00, 5'd0, 5'd1, 5'd2, 1, 1);
        push(5'd0, 1'b0);
        tick();
        set_id(1, 1, 0, 0, 0, 2'b00, 5'd13, 5'd0, 5'd0, 1, 1);
        push(5'd13, 1'b0);
        tick();
        n_checks++;
        if (fwd_a_sel !== 2'b00 || fwd_b_sel !== 2'b00) begin
            n_fail++;
            $display("FAIL x0_mem_no_fwd: got a=%b b=%b, expected 00 00", fwd_a_sel, fwd_b_sel);
        end
        drain("x0_mem");
    endtask

    task automatic test_reset_mid();
        for (int i = 1; i <= 3; i++) begin
            set_id(1, 1, 1, 0, 0, 2'b00, 5'(i), 5'd0, 5'd0, 0, 0);
            tick();
        end
        n_checks++;
        if ({ex_valid, mem_valid, mem_store, wb_write} !== 4'b1111) begin
            n_fail++;
            $display("FAIL pre_reset_full: got ex/mem/store/wb=%b, expected 1111",
                     {ex_valid, mem_valid, mem_store, wb_write});
        end
        rst_n = 1'b0;
        set_idle();
        #1;
        n_checks++;
        if (all_outs !== 29'd0) begin
            n_fail++;
            $display("FAIL async_reset: got %h, expected 0", all_outs);
        end
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            n_checks++;
            if ({ex_valid, mem_valid, wb_write} !== 3'b000) begin
                n_fail++;
                $display("FAIL squashed_after_reset[%0d]: got ex/mem/wb=%b, expected 000",
                         i, {ex_valid, mem_valid, wb_write});
            end
        end
        set_id(1, 1, 0, 0, 0, 2'b00, 5'd7, 5'd0, 5'd0, 0, 0);
        push(5'd7, 1'b0);
        tick();
        n_checks++;
        if (ex_valid !== 1'b1 || ex_alu_op !== 3'd7) begin
            n_fail++;
            $display("FAIL first_after_reset: got ex_v=%0b op=%0d, expected 1 7", ex_valid, ex_alu_op);
        end
        drain("reset_mid");
    endtask

    initial begin
        set_idle();
        rst_n = 1'b0;
        test_reset();
        test_alu_ripple();
        test_load_use();
        test_forwarding();
        test_redirect();
        test_x0();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
